// File: rtl/sd_ctrl_pkg.sv
// Shared constants, state encoding and frame helpers for the SD command sequencer.
package sd_ctrl_pkg;

    localparam int unsigned RSP_MAX = 17;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned ARG_W   = 32;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ADR_W   = 3;
    localparam int unsigned DAT_W   = 8;
    localparam int unsigned CRC_W   = 7;
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned BCNT_W  = 6;
    localparam int unsigned BYTE_W  = 3;

    // Controller register map
    localparam logic [ADR_W-1:0] ADR_TX_CMD = 3'd0;
    localparam logic [ADR_W-1:0] ADR_RX_CMD = 3'd1;
    localparam logic [ADR_W-1:0] ADR_STATUS = 3'd4;
    localparam logic [ADR_W-1:0] ADR_TIMER  = 3'd6;

    // Status register bit positions
    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_RX_EMPTY = 1;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CRC    = 4'd1,
        S_TXPOLL = 4'd2,
        S_TXWR   = 4'd3,
        S_RXCHK  = 4'd4,
        S_RXPOLL = 4'd5,
        S_RXRD   = 4'd6,
        S_TMR    = 4'd7,
        S_DONE   = 4'd8
    } seq_state_e;

    // Byte n of the 6-byte command frame; bytes 0-4 come from the latched frame, byte 5 carries CRC and end bit.
    function automatic logic [DAT_W-1:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                                    input logic [BYTE_W-1:0]  n,
                                                    input logic [CRC_W-1:0]   crc);
        logic [DAT_W-1:0] b;
        case (n)
            3'd0:    b = frame[39:32];
            3'd1:    b = frame[31:24];
            3'd2:    b = frame[23:16];
            3'd3:    b = frame[15:8];
            3'd4:    b = frame[7:0];
            default: b = {crc, 1'b1};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1), MSB first, synchronous clear.
module sd_crc7_serial
    import sd_ctrl_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             bit_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CRC_W-1:0] crc_o
);

    logic fb;

    assign fb = bit_i ^ crc_o[CRC_W-1];

    // Shift one message bit per enabled cycle into the CRC register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            crc_o <= '0;
        end else if (clr_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : CRC_W'(0));
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Wishbone master that sends one SD command frame to the FIFO controller and collects its response.
module sd_cmd_sequencer
    import sd_ctrl_pkg::*;
(
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               req_i,
    input  logic [IDX_W-1:0]   cmd_idx_i,
    input  logic [ARG_W-1:0]   cmd_arg_i,
    input  logic [CNT_W-1:0]   rsp_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   rsp_cnt_o,
    input  logic [CNT_W-1:0]   rsp_idx_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic [ADR_W-1:0]   m_adr_o,
    output logic [DAT_W-1:0]   m_dat_o,
    input  logic [DAT_W-1:0]   m_dat_i,
    output logic               m_we_o,
    output logic [3:0]         m_sel_o,
    output logic               m_cyc_o,
    output logic               m_stb_o,
    input  logic               m_ack_i
);

    seq_state_e          state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DAT_W-1:0]    wdat_q, wdat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    rsp_cnt_q, rsp_cnt_d;
    logic [CNT_W-1:0]    rsp_len_q, rsp_len_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   byte_n_q, byte_n_d;

    logic                crc_en, crc_clr, crc_bit;
    logic [CRC_W-1:0]    crc;
    logic [BCNT_W-1:0]   crc_pos;
    logic [DAT_W-1:0]    tx_byte;

    logic                bus_state;
    logic [ADR_W-1:0]    acc_adr;
    logic                acc_we;
    logic [DAT_W-1:0]    acc_dat;
    logic                ack_seen;
    logic                buf_we;

    logic [DAT_W-1:0]    rsp_buf [RSP_MAX];

    // CRC is fed from the latched frame, MSB first
    assign crc_pos = BCNT_W'(FRAME_W - 1) - bit_cnt_q;
    assign crc_bit = frame_q[crc_pos];
    assign tx_byte = frame_byte(frame_q, byte_n_q, crc);

    sd_crc7_serial u_crc (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bit_i    (crc_bit),
        .en_i     (crc_en),
        .clr_i    (crc_clr),
        .crc_o    (crc)
    );

    // Bus access attributes for the states that own a Wishbone transfer
    always_comb begin
        bus_state = 1'b0;
        acc_adr   = ADR_STATUS;
        acc_we    = 1'b0;
        acc_dat   = wdat_q;
        case (state_q)
            S_TXPOLL, S_RXPOLL: begin
                bus_state = 1'b1;
            end
            S_TXWR: begin
                bus_state = 1'b1;
                acc_adr   = ADR_TX_CMD;
                acc_we    = 1'b1;
                acc_dat   = tx_byte;
            end
            S_RXRD: begin
                bus_state = 1'b1;
                acc_adr   = ADR_RX_CMD;
            end
            S_TMR: begin
                bus_state = 1'b1;
                acc_adr   = ADR_TIMER;
            end
            default: begin
                bus_state = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        rsp_cnt_d = rsp_cnt_q;
        rsp_len_d = rsp_len_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        byte_n_d  = byte_n_q;
        crc_en    = 1'b0;
        crc_clr   = 1'b0;
        buf_we    = 1'b0;
        ack_seen  = 1'b0;

        // Classic cycle: raise after an idle cycle, hold until ack, drop the cycle after ack
        if (bus_state) begin
            if (!cyc_q) begin
                cyc_d  = 1'b1;
                we_d   = acc_we;
                adr_d  = acc_adr;
                wdat_d = acc_dat;
            end else if (m_ack_i) begin
                cyc_d    = 1'b0;
                we_d     = 1'b0;
                ack_seen = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req_i) begin
                    frame_d   = {2'b01, cmd_idx_i, cmd_arg_i};
                    rsp_len_d = (rsp_len_i > CNT_W'(RSP_MAX)) ? CNT_W'(RSP_MAX) : rsp_len_i;
                    timeout_d = 1'b0;
                    rsp_cnt_d = '0;
                    bit_cnt_d = '0;
                    byte_n_d  = '0;
                    crc_clr   = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_CRC;
                end
            end
            S_CRC: begin
                crc_en    = 1'b1;
                bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                if (bit_cnt_q == BCNT_W'(FRAME_W - 1)) begin
                    state_d = S_TXPOLL;
                end
            end
            S_TXPOLL: begin
                if (ack_seen && !m_dat_i[ST_TX_FULL]) begin
                    state_d = S_TXWR;
                end
            end
            S_TXWR: begin
                if (ack_seen) begin
                    if (byte_n_q == BYTE_W'(5)) begin
                        if (rsp_len_q != '0) begin
                            state_d = S_RXCHK;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        byte_n_d = byte_n_q + BYTE_W'(1);
                        state_d  = S_TXPOLL;
                    end
                end
            end
            S_RXCHK: begin
                if (rsp_cnt_q == rsp_len_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RXPOLL;
                end
            end
            S_RXPOLL: begin
                if (ack_seen) begin
                    state_d = m_dat_i[ST_RX_EMPTY] ? S_TMR : S_RXRD;
                end
            end
            S_RXRD: begin
                if (ack_seen) begin
                    buf_we    = 1'b1;
                    rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
                    state_d   = S_RXCHK;
                end
            end
            S_TMR: begin
                if (ack_seen) begin
                    if (m_dat_i == '0) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_RXPOLL;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rsp_cnt_q <= '0;
            rsp_len_q <= '0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            byte_n_q  <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            rsp_cnt_q <= rsp_cnt_d;
            rsp_len_q <= rsp_len_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            byte_n_q  <= byte_n_d;
        end
    end

    // Response buffer capture; contents survive until overwritten by a later request
    always_ff @(posedge wb_clk_i) begin
        if (buf_we && (rsp_cnt_q < CNT_W'(RSP_MAX))) begin
            rsp_buf[rsp_cnt_q] <= m_dat_i;
        end
    end

    assign rsp_dat_o = (rsp_idx_i < CNT_W'(RSP_MAX)) ? rsp_buf[rsp_idx_i] : '0;

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign rsp_cnt_o = rsp_cnt_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = wdat_q;
    assign m_we_o    = we_q;
    assign m_sel_o   = 4'hF;
    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;

endmodule
